// File: rtl/remote_comm.sv
// remote_comm: host-side UART link, sends a 16-bit command as two 8N1 bytes (high first) and receives 1-byte responses.
// Latency: TX start bit 1 clk after snd_cmd; cmd_snt 20*BAUD_DIV+1 clks after strobe; resp ~9.5*BAUD_DIV+1 clks after RX start edge.
// Backpressure: none; snd_cmd is ignored while a send is in flight, and resp is overwritten by each new received byte.
// Optional RX_SYNC: define RMT_RX_SYNC_EN to add a 2-flop synchronizer on RX (+2 clks RX latency).
module remote_comm #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic        TX,
  input  logic [15:0] cmd,
  input  logic        snd_cmd,
  output logic        cmd_snt,
  output logic        resp_rdy,
  output logic [7:0]  resp
);

  // Baud counters are never narrower than 12 bits so the default divider fits.
  localparam int CW = ($clog2(BAUD_DIV) > 12) ? $clog2(BAUD_DIV) : 12;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, SEND_HI, SEND_LO} tx_state_e;
  typedef enum logic {RX_IDLE, RX_BUSY} rx_state_e;

  // ---------------- transmit side ----------------
  tx_state_e       tx_state_q, tx_state_d;
  logic [15:0]     cmd_hold_q, cmd_hold_d;
  logic [CW-1:0]   tx_baud_q, tx_baud_d;
  logic [3:0]      tx_bit_q, tx_bit_d;
  logic            tx_q, tx_d;
  logic            cmd_snt_q, cmd_snt_d;
  logic [7:0]      tx_byte;
  logic            snd_acc;

  // A strobe only counts when the sender is idle; it also clears resp_rdy.
  assign snd_acc = (tx_state_q == IDLE) && snd_cmd;
  assign tx_byte = (tx_state_q == SEND_HI) ? cmd_hold_q[15:8] : cmd_hold_q[7:0];

  // Send FSM: tx_q is the registered line value for the bit that starts on the next edge.
  always_comb begin
    tx_state_d = tx_state_q;
    cmd_hold_d = cmd_hold_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_d       = tx_q;
    cmd_snt_d  = cmd_snt_q;
    case (tx_state_q)
      IDLE: begin
        if (snd_cmd) begin
          cmd_hold_d = cmd;
          cmd_snt_d  = 1'b0;
          tx_d       = 1'b0;
          tx_baud_d  = '0;
          tx_bit_d   = 4'd0;
          tx_state_d = SEND_HI;
        end
      end
      SEND_HI, SEND_LO: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d = '0;
          if (tx_bit_q == 4'd9) begin
            // End of stop bit: chain straight into the low byte, or finish.
            tx_bit_d = 4'd0;
            if (tx_state_q == SEND_HI) begin
              tx_d       = 1'b0;
              tx_state_d = SEND_LO;
            end else begin
              tx_d       = 1'b1;
              cmd_snt_d  = 1'b1;
              tx_state_d = IDLE;
            end
          end else begin
            tx_bit_d = tx_bit_q + 4'd1;
            tx_d     = (tx_bit_q == 4'd8) ? 1'b1 : tx_byte[tx_bit_q[2:0]];
          end
        end else begin
          tx_baud_d = tx_baud_q + CW'(1);
        end
      end
      default: tx_state_d = IDLE;
    endcase
  end

  // Transmit state registers; reset forces the line idle-high immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= IDLE;
      cmd_hold_q <= '0;
      tx_baud_q  <= '0;
      tx_bit_q   <= 4'd0;
      tx_q       <= 1'b1;
      cmd_snt_q  <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      cmd_hold_q <= cmd_hold_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_q       <= tx_d;
      cmd_snt_q  <= cmd_snt_d;
    end
  end

  assign TX      = tx_q;
  assign cmd_snt = cmd_snt_q;

  // ---------------- receive side ----------------
  logic rx_in;

`ifdef RMT_RX_SYNC_EN
  logic rx_s1_q, rx_s2_q;

  // Two-flop synchronizer, preset to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
    end else begin
      rx_s1_q <= RX;
      rx_s2_q <= rx_s1_q;
    end
  end

  assign rx_in = rx_s2_q;
`else
  assign rx_in = RX;
`endif

  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_baud_q, rx_baud_d;
  logic [3:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_prev_q, rx_prev_d;
  logic [7:0]    resp_q, resp_d;
  logic          resp_rdy_q, resp_rdy_d;
  logic          rx_fall;

  assign rx_fall = rx_prev_q & ~rx_in;

  // Receive FSM: bit 0 is the half-bit wait to start-bit centre, bits 1..8 data, bit 9 stop.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_prev_d  = rx_in;
    resp_d     = resp_q;
    resp_rdy_d = resp_rdy_q;
    if (snd_acc) resp_rdy_d = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_state_d = RX_BUSY;
          rx_baud_d  = '0;
          rx_bit_d   = 4'd0;
          resp_rdy_d = 1'b0;
        end
      end
      RX_BUSY: begin
        if (rx_bit_q == 4'd0) begin
          if (rx_baud_q == HALF_LAST) begin
            rx_baud_d = '0;
            rx_bit_d  = 4'd1;
          end else begin
            rx_baud_d = rx_baud_q + CW'(1);
          end
        end else if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d = '0;
          if (rx_bit_q == 4'd9) begin
            // Stop-bit sample point: accept the byte without checking the stop level.
            resp_d     = rx_shift_q;
            resp_rdy_d = 1'b1;
            rx_bit_d   = 4'd0;
            rx_state_d = RX_IDLE;
          end else begin
            rx_shift_d = {rx_in, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 4'd1;
          end
        end else begin
          rx_baud_d = rx_baud_q + CW'(1);
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Receive state registers; reset discards any partial byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= 4'd0;
      rx_shift_q <= 8'h00;
      rx_prev_q  <= 1'b1;
      resp_q     <= 8'h00;
      resp_rdy_q <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_prev_q  <= rx_prev_d;
      resp_q     <= resp_d;
      resp_rdy_q <= resp_rdy_d;
    end
  end

  assign resp     = resp_q;
  assign resp_rdy = resp_rdy_q;

endmodule

// File: tb/tb_remote_comm.sv
// tb_remote_comm: directed bench for remote_comm with a short baud divider.
// Latency: expected values are hand-derived cycle counts relative to the strobe / RX start edge.
// Backpressure: not applicable; the bench drives the strobe and the RX line directly.
module tb_remote_comm;

  localparam int B = 16;
`ifdef RMT_RX_SYNC_EN
  localparam int RXLAT = 155;
`else
  localparam int RXLAT = 153;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RX;
  logic        TX;
  logic [15:0] cmd;
  logic        snd_cmd;
  logic        cmd_snt;
  logic        resp_rdy;
  logic [7:0]  resp;

  int checks = 0;
  int errors = 0;
  int snt_rises = 0;
  logic snt_prev = 1'b0;

  int n_lat, n_rx, n_w, r0;
  logic [7:0] b1, b2, b3, b4;

  always #5 clk = ~clk;

  remote_comm #(.BAUD_DIV(B)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RX       (RX),
    .TX       (TX),
    .cmd      (cmd),
    .snd_cmd  (snd_cmd),
    .cmd_snt  (cmd_snt),
    .resp_rdy (resp_rdy),
    .resp     (resp)
  );

  // Count rising edges of cmd_snt, sampled away from the active edge.
  always @(negedge clk) begin
    if (cmd_snt === 1'b1 && snt_prev === 1'b0) snt_rises++;
    snt_prev = cmd_snt;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [15:0] c);
    cmd = c;
    snd_cmd = 1'b1;
    @(negedge clk);
    snd_cmd = 1'b0;
  endtask

  // Wait for a TX start bit, then sample each bit at its centre.
  task automatic tx_frame(input string tag, output logic [7:0] b);
    int n;
    n = 0;
    b = 8'h00;
    while (TX !== 1'b0 && n < 4 * B) begin
      cyc(1);
      n++;
    end
    chk({tag, "_start"}, {31'b0, TX}, 32'd0);
    cyc(B / 2);
    chk({tag, "_startmid"}, {31'b0, TX}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      cyc(B);
      b[i] = TX;
    end
    cyc(B);
    chk({tag, "_stop"}, {31'b0, TX}, 32'd1);
  endtask

  task automatic rx_send(input logic [7:0] b);
    RX = 1'b0;
    cyc(B);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      cyc(B);
    end
    RX = 1'b1;
    cyc(B);
  endtask

  task automatic wait_snt(input string tag, input int lim, output int n);
    n = 0;
    while (cmd_snt !== 1'b1 && n < lim) begin
      cyc(1);
      n++;
    end
    chk(tag, {31'b0, cmd_snt}, 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    RX = 1'b1;
    snd_cmd = 1'b0;
    cmd = 16'h0000;
    cyc(2);
    chk("rst_tx", {31'b0, TX}, 32'd1);
    chk("rst_snt", {31'b0, cmd_snt}, 32'd0);
    chk("rst_rdy", {31'b0, resp_rdy}, 32'd0);
    chk("rst_resp", {24'b0, resp}, 32'h00);
    rst_n = 1'b1;
    cyc(2);

    // 0x4004 with an ignored 0x2002 strobe and cmd changes mid-flight.
    r0 = snt_rises;
    strobe(16'h4004);
    chk("tx_start_lat", {31'b0, TX}, 32'd0);
    chk("snt_clr", {31'b0, cmd_snt}, 32'd0);
    fork
      begin
        tx_frame("f40", b1);
        tx_frame("f04", b2);
      end
      begin
        n_lat = 1;
        while (cmd_snt !== 1'b1 && n_lat < 1000) begin
          cyc(1);
          n_lat++;
        end
      end
      begin
        cyc(49);
        strobe(16'h2002);
        cmd = 16'hFFFF;
      end
    join
    chk("f40_byte", {24'b0, b1}, 32'h40);
    chk("f04_byte", {24'b0, b2}, 32'h04);
    chk("snt_lat", n_lat, 20 * B + 1);
    cyc(2 * B);
    chk("snt_held", {31'b0, cmd_snt}, 32'd1);
    chk("snt_once", snt_rises - r0, 32'd1);

    // Receive 0xA5.
    fork
      rx_send(8'hA5);
      begin
        n_rx = 0;
        while (resp_rdy !== 1'b1 && n_rx < 400) begin
          cyc(1);
          n_rx++;
        end
      end
    join
    chk("rx_lat", n_rx, RXLAT);
    chk("rx_a5", {24'b0, resp}, 32'hA5);
    chk("rx_rdy", {31'b0, resp_rdy}, 32'd1);

    // Next start bit clears resp_rdy; then reset lands mid high-byte.
    fork
      rx_send(8'h3C);
      begin
        cyc(4);
        chk("rdy_clr_start", {31'b0, resp_rdy}, 32'd0);
        chk("resp_hold", {24'b0, resp}, 32'hA5);
      end
      begin
        cyc(140);
        strobe(16'h4004);
        cyc(29);
      end
    join
    chk("pre_rst_rdy", {31'b0, resp_rdy}, 32'd1);
    chk("pre_rst_resp", {24'b0, resp}, 32'h3C);
    chk("pre_rst_tx", {31'b0, TX}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", {31'b0, TX}, 32'd1);
    chk("mid_rst_snt", {31'b0, cmd_snt}, 32'd0);
    chk("mid_rst_rdy", {31'b0, resp_rdy}, 32'd0);
    chk("mid_rst_resp", {24'b0, resp}, 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);

    // Full duplex: send 0x1234 while receiving 0x5A.
    fork
      rx_send(8'h5A);
      begin
        strobe(16'h1234);
        tx_frame("f12", b1);
        tx_frame("f34", b2);
        wait_snt("dup_snt", 4 * B, n_w);
      end
    join
    chk("f12_byte", {24'b0, b1}, 32'h12);
    chk("f34_byte", {24'b0, b2}, 32'h34);
    chk("dup_resp", {24'b0, resp}, 32'h5A);
    chk("dup_rdy", {31'b0, resp_rdy}, 32'd1);

    // Back-to-back commands, second strobe the cycle cmd_snt is seen.
    r0 = snt_rises;
    strobe(16'hBEEF);
    fork
      begin
        tx_frame("bb0", b1);
        tx_frame("bb1", b2);
        tx_frame("bb2", b3);
        tx_frame("bb3", b4);
      end
      begin
        wait_snt("bb_snt1", 1000, n_w);
        strobe(16'h0F0F);
        chk("bb_snt_drop", {31'b0, cmd_snt}, 32'd0);
        wait_snt("bb_snt2", 1000, n_w);
      end
    join
    chk("bb0_byte", {24'b0, b1}, 32'hBE);
    chk("bb1_byte", {24'b0, b2}, 32'hEF);
    chk("bb2_byte", {24'b0, b3}, 32'h0F);
    chk("bb3_byte", {24'b0, b4}, 32'h0F);
    chk("bb_snt_rises", snt_rises - r0, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
